// File: rtl/alu_decode.sv
// Decodes the RV32I integer-ALU subset into ALU op, operands and rd, queued in a 2-entry FIFO.
// Latency: 1 cycle from the accepting edge to out_valid; no bypass when empty.
// Backpressure: in_ready drops when both entries are occupied, independent of out_ready.
module alu_decode #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  instr,
   input  logic [N-1:0] pc,
   input  logic [N-1:0] rs1_val,
   input  logic [N-1:0] rs2_val,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [2:0]   type_,
   output logic [N-1:0] in1,
   output logic [N-1:0] in2,
   output logic [4:0]   rd,
   output logic         illegal
);

   // ALU operation codes shared with the execute stage
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   logic [2:0]   dec_type;
   logic [N-1:0] dec_in1;
   logic [N-1:0] dec_in2;
   logic [4:0]   dec_rd;
   logic         dec_ill;

   logic signed [11:0] imm_i12;
   logic signed [31:0] imm_u32;
   logic [N-1:0]       imm_i;
   logic [N-1:0]       imm_u;

   // FIFO storage and control state
   logic [2:0]   type_q [2];
   logic [2:0]   type_d [2];
   logic [N-1:0] in1_q  [2];
   logic [N-1:0] in1_d  [2];
   logic [N-1:0] in2_q  [2];
   logic [N-1:0] in2_d  [2];
   logic [4:0]   rd_q   [2];
   logic [4:0]   rd_d   [2];
   logic         ill_q  [2];
   logic         ill_d  [2];
   logic [1:0]   count_q, count_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic         enq, deq;

   // Decode the offered instruction; illegal encodings collapse to an all-zero ADD
   always_comb begin
      imm_i12  = instr[31:20];
      imm_u32  = {instr[31:12], 12'b0};
      imm_i    = N'(imm_i12);
      imm_u    = N'(imm_u32);
      dec_type = ALU_ADD;
      dec_in1  = '0;
      dec_in2  = '0;
      dec_rd   = instr[11:7];
      dec_ill  = 1'b0;
      case (instr[6:0])
         OPC_OP: begin
            dec_in1 = rs1_val;
            dec_in2 = rs2_val;
            if (instr[31:25] == 7'b0000000) begin
               case (instr[14:12])
                  3'b000:  dec_type = ALU_ADD;
                  3'b100:  dec_type = ALU_XOR;
                  3'b110:  dec_type = ALU_OR;
                  3'b111:  dec_type = ALU_AND;
                  default: dec_ill  = 1'b1;
               endcase
            end else if (instr[31:25] == 7'b0100000 && instr[14:12] == 3'b000) begin
               dec_type = ALU_SUB;
            end else begin
               dec_ill = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_in1 = rs1_val;
            dec_in2 = imm_i;
            case (instr[14:12])
               3'b000:  dec_type = ALU_ADD;
               3'b100:  dec_type = ALU_XOR;
               3'b110:  dec_type = ALU_OR;
               3'b111:  dec_type = ALU_AND;
               default: dec_ill  = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_in2 = imm_u;
         end
         OPC_AUIPC: begin
            dec_in1 = pc;
            dec_in2 = imm_u;
         end
         default: dec_ill = 1'b1;
      endcase
      if (dec_ill) begin
         dec_type = ALU_ADD;
         dec_in1  = '0;
         dec_in2  = '0;
         dec_rd   = 5'd0;
      end
   end

   assign in_ready  = (count_q != 2'd2) && !reset;
   assign out_valid = (count_q != 2'd0);
   assign enq       = in_valid && in_ready;
   assign deq       = out_valid && out_ready;

   // FIFO next state: write decoded fields at wr_ptr, advance pointers on each handshake
   always_comb begin
      type_d   = type_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      rd_d     = rd_q;
      ill_d    = ill_q;
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (enq) begin
         type_d[wr_ptr_q] = dec_type;
         in1_d[wr_ptr_q]  = dec_in1;
         in2_d[wr_ptr_q]  = dec_in2;
         rd_d[wr_ptr_q]   = dec_rd;
         ill_d[wr_ptr_q]  = dec_ill;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (deq) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (enq && !deq) begin
         count_d = count_q + 2'd1;
      end else if (deq && !enq) begin
         count_d = count_q - 2'd1;
      end
   end

   // State registers; reset empties the FIFO and zeroes stored fields so outputs read 0
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            type_q[i] <= ALU_ADD;
            in1_q[i]  <= '0;
            in2_q[i]  <= '0;
            rd_q[i]   <= '0;
            ill_q[i]  <= 1'b0;
         end
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         type_q   <= type_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         rd_q     <= rd_d;
         ill_q    <= ill_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   assign type_   = type_q[rd_ptr_q];
   assign in1     = in1_q[rd_ptr_q];
   assign in2     = in2_q[rd_ptr_q];
   assign rd      = rd_q[rd_ptr_q];
   assign illegal = ill_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_decode.sv
// Scoreboarded bench for alu_decode: directed instructions with hand-computed results.
module tb_alu_decode;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_XOR = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;

   typedef struct packed {
      logic [2:0]  t;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  r;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  type_;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [4:0]  rd;
   logic        illegal;

   int errors = 0;
   int checks = 0;
   exp_t sb[$];

   alu_decode #(.N(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .type_(type_), .in1(in1), .in2(in2), .rd(rd), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] r, input logic ill);
      exp_t e;
      e.t = t; e.a = a; e.b = b; e.r = r; e.ill = ill;
      return e;
   endfunction

   // Offer one instruction starting just after a rising edge; push expectation on acceptance
   task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e, output int waited);
      logic ok;
      logic done;
      instr = i; pc = p; rs1_val = a; rs2_val = b; in_valid = 1'b1;
      waited = 0;
      done = 1'b0;
      while (!done && waited < 50) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         if (ok) begin
            sb.push_back(e);
            done = 1'b1;
         end else begin
            waited++;
         end
      end
      if (!done) chk("send_timeout", 64'(waited), 64'd0);
      #1 in_valid = 1'b0;
   endtask

   // Monitor: every consumed head entry is compared against the oldest expectation
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {32'(type_), in1}, 64'd0 - 64'd1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("type_",   64'(type_),   64'(e.t));
            chk("in1",     64'(in1),     64'(e.a));
            chk("in2",     64'(in2),     64'(e.b));
            chk("rd",      64'(rd),      64'(e.r));
            chk("illegal", 64'(illegal), 64'(e.ill));
         end
      end
   end

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk(name, 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   int w;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd0);
      chk("rst_fields",    {27'(type_), 32'(rd), 1'b0, 4'(illegal)}, 64'd0);
      chk("rst_in1",       64'(in1), 64'd0);
      chk("rst_in2",       64'(in2), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      out_ready = 1'b1;

      // First transfer and latency
      send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b0), w);
      chk("first_accept_wait", 64'(w), 64'd0);
      @(negedge clk);
      chk("latency_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;

      // Back-to-back legal decodes at full throughput
      send(32'hFFF30293, 32'h0,   32'h10,   32'h0, mk(ALU_ADD, 32'h10,   32'hFFFFFFFF, 5'd5, 1'b0), w);
      chk("tput_addi", 64'(w), 64'd0);
      send(32'h12345097, 32'h100, 32'h0,    32'h0, mk(ALU_ADD, 32'h100,  32'h12345000, 5'd1, 1'b0), w);
      chk("tput_auipc", 64'(w), 64'd0);
      send(32'hABCDE3B7, 32'h200, 32'h55,   32'h66, mk(ALU_ADD, 32'h0,   32'hABCDE000, 5'd7, 1'b0), w);
      chk("tput_lui", 64'(w), 64'd0);
      send(32'h0F00E213, 32'h0,   32'h8000, 32'h0, mk(ALU_OR,  32'h8000, 32'h000000F0, 5'd4, 1'b0), w);
      send(32'hFF00F113, 32'h0,   32'h1234, 32'h0, mk(ALU_AND, 32'h1234, 32'hFFFFFFF0, 5'd2, 1'b0), w);
      send(32'h402081B3, 32'h0,   32'd9,    32'd4, mk(ALU_SUB, 32'd9,    32'd4,        5'd3, 1'b0), w);
      send(32'h0020E1B3, 32'h0,   32'hA,    32'hB, mk(ALU_OR,  32'hA,    32'hB,        5'd3, 1'b0), w);
      send(32'h0020F1B3, 32'h0,   32'hC,    32'hD, mk(ALU_AND, 32'hC,    32'hD,        5'd3, 1'b0), w);
      send(32'h00208033, 32'h0,   32'h1,    32'h2, mk(ALU_ADD, 32'h1,    32'h2,        5'd0, 1'b0), w);
      // xor then illegal funct7/funct3 combination, then more illegal encodings
      send(32'h0020C1B3, 32'h0,   32'hF0,   32'h0F, mk(ALU_XOR, 32'hF0,  32'h0F,       5'd3, 1'b0), w);
      send(32'h4020C1B3, 32'h0,   32'hF0,   32'h0F, mk(ALU_ADD, 32'h0,   32'h0,        5'd0, 1'b1), w);
      send(32'h0050A093, 32'h0,   32'h77,   32'h0, mk(ALU_ADD, 32'h0,    32'h0,        5'd0, 1'b1), w);
      send(32'h00000073, 32'h40,  32'h77,   32'h88, mk(ALU_ADD, 32'h0,   32'h0,        5'd0, 1'b1), w);
      chk("tput_last", 64'(w), 64'd0);
      drain("drain_1");

      // Backpressure: fill with out_ready low, third waits until an entry leaves
      out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(ALU_ADD, 32'd1, 32'd2, 5'd3, 1'b0), w);
      send(32'h0020C1B3, 32'h0, 32'd3, 32'd4, mk(ALU_XOR, 32'd3, 32'd4, 5'd3, 1'b0), w);
      @(negedge clk);
      chk("full_in_ready",  64'(in_ready),  64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      fork
         begin
            send(32'h402081B3, 32'h0, 32'd10, 32'd3, mk(ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b0), w);
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            chk("full_no_passthru", 64'(in_ready), 64'd0);
         end
      join
      chk("third_waited", 64'(w >= 3), 64'd1);
      drain("drain_2");

      // Reset mid-operation with a full FIFO
      out_ready = 1'b0;
      send(32'h002081B3, 32'h0, 32'd1, 32'd1, mk(ALU_ADD, 32'd1, 32'd1, 5'd3, 1'b0), w);
      send(32'h002081B3, 32'h0, 32'd2, 32'd2, mk(ALU_ADD, 32'd2, 32'd2, 5'd3, 1'b0), w);
      reset = 1'b1;
      out_ready = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 64'(out_valid), 64'd0);
      chk("post_rst_in_ready",  64'(in_ready),  64'd1);
      repeat (4) @(posedge clk);
      #1;
      send(32'h0020E1B3, 32'h0, 32'h5, 32'h6, mk(ALU_OR, 32'h5, 32'h6, 5'd3, 1'b0), w);
      drain("drain_3");
      @(negedge clk);
      chk("final_empty", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
